// File: rtl/tx_serial_param.sv
// tx_serial_param: parametrised asynchronous serial transmitter (start, DATA_BITS, optional parity, stop bits).
// Optional line-break generation is compiled in with `define TX_BREAK_EN (adds input quebra).
module tx_serial_param #(
   parameter int DATA_BITS = 7,
   parameter int PARITY    = 2,
   parameter int STOP_BITS = 1,
   parameter int BAUD_DIV  = 434
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 partida,
   input  logic [DATA_BITS-1:0] dados,
`ifdef TX_BREAK_EN
   input  logic                 quebra,
`endif
   output logic                 saida_serial,
   output logic                 pronto,
   output logic                 ocupado,
   output logic                 db_partida,
   output logic                 db_saida_serial,
   output logic [3:0]           db_estado
);

   localparam int N      = 1 + DATA_BITS + ((PARITY != 0) ? 1 : 0) + STOP_BITS;
   localparam int BAUD_W = $clog2(BAUD_DIV);
   localparam int BIT_W  = $clog2(N + 1);

   localparam logic [BAUD_W-1:0] BAUD_LAST     = BAUD_W'(BAUD_DIV - 1);
   localparam logic [BAUD_W-1:0] BAUD_HOLD_END = BAUD_W'(BAUD_DIV - 2);
   localparam logic [BIT_W-1:0]  BIT_LAST      = BIT_W'(N - 1);
   localparam logic [BIT_W-1:0]  STOP_LAST     = BIT_W'(STOP_BITS - 1);

   typedef enum logic [3:0] {
      INICIAL     = 4'd0,
      PREPARACAO  = 4'd1,
      ESPERA      = 4'd2,
      TRANSMISSAO = 4'd3,
      FINAL       = 4'd4,
      QUEBRA      = 4'd5
   } state_t;

   state_t             r_estado;
   logic [N-1:0]       r_shift;
   logic [BAUD_W-1:0]  r_baud_cnt;
   logic [BIT_W-1:0]   r_bit_cnt;
   logic               r_saida;
   logic               r_pronto;
   logic               r_ocupado;
   logic               r_partida_q;
`ifdef TX_BREAK_EN
   logic               r_brk_rel;
`endif

   logic               w_partida_edge;
   logic               w_parity;
   logic [N-1:0]       w_frame;

   assign w_partida_edge = partida & ~r_partida_q;

   always_comb begin
      w_parity             = (PARITY == 1) ? ^dados : ~^dados;
      w_frame              = '1;
      w_frame[0]           = 1'b0;
      w_frame[DATA_BITS:1] = dados;
      if (PARITY != 0)
         w_frame[DATA_BITS+1] = w_parity;
   end

   // Each bit spends BAUD_DIV-1 cycles in ESPERA plus one in TRANSMISSAO,
   // so the line changes exactly every BAUD_DIV clocks.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_estado    <= INICIAL;
         r_shift     <= '0;
         r_baud_cnt  <= '0;
         r_bit_cnt   <= '0;
         r_saida     <= 1'b1;
         r_pronto    <= 1'b0;
         r_ocupado   <= 1'b0;
         r_partida_q <= 1'b1;   // a level held through reset is not an edge
`ifdef TX_BREAK_EN
         r_brk_rel   <= 1'b0;
`endif
      end else begin
         r_partida_q <= partida;
         r_pronto    <= 1'b0;
         case (r_estado)
            INICIAL: begin
               r_saida   <= 1'b1;
               r_ocupado <= 1'b0;
`ifdef TX_BREAK_EN
               if (quebra) begin
                  r_estado  <= QUEBRA;
                  r_saida   <= 1'b0;
                  r_ocupado <= 1'b1;
                  r_brk_rel <= 1'b0;
               end else if (w_partida_edge) begin
                  r_estado  <= PREPARACAO;
                  r_ocupado <= 1'b1;
               end
`else
               if (w_partida_edge) begin
                  r_estado  <= PREPARACAO;
                  r_ocupado <= 1'b1;
               end
`endif
            end
            PREPARACAO: begin
               r_shift    <= w_frame;
               r_baud_cnt <= '0;
               r_bit_cnt  <= '0;
               r_saida    <= w_frame[0];
               r_estado   <= ESPERA;
            end
            ESPERA: begin
               if (r_baud_cnt == BAUD_HOLD_END)
                  r_estado <= TRANSMISSAO;
               else
                  r_baud_cnt <= r_baud_cnt + 1'b1;
            end
            TRANSMISSAO: begin
               r_shift    <= {1'b1, r_shift[N-1:1]};
               r_bit_cnt  <= r_bit_cnt + 1'b1;
               r_baud_cnt <= '0;
               if (r_bit_cnt == BIT_LAST) begin
                  r_estado <= FINAL;
                  r_saida  <= 1'b1;
                  r_pronto <= 1'b1;
               end else begin
                  r_saida  <= r_shift[1];
                  r_estado <= ESPERA;
               end
            end
            FINAL: begin
               r_saida   <= 1'b1;
               r_ocupado <= 1'b0;
               r_estado  <= INICIAL;
            end
`ifdef TX_BREAK_EN
            QUEBRA: begin
               if (!r_brk_rel) begin
                  if (!quebra) begin
                     r_brk_rel  <= 1'b1;
                     r_saida    <= 1'b1;
                     r_baud_cnt <= '0;
                     r_bit_cnt  <= '0;
                  end
               end else if (r_baud_cnt == BAUD_LAST) begin
                  r_baud_cnt <= '0;
                  if (r_bit_cnt == STOP_LAST) begin
                     r_estado  <= INICIAL;
                     r_ocupado <= 1'b0;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 1'b1;
                  end
               end else begin
                  r_baud_cnt <= r_baud_cnt + 1'b1;
               end
            end
`endif
            default: begin
               r_estado  <= INICIAL;
               r_saida   <= 1'b1;
               r_ocupado <= 1'b0;
            end
         endcase
      end
   end

   assign saida_serial    = r_saida;
   assign db_saida_serial = r_saida;
   assign pronto          = r_pronto;
   assign ocupado         = r_ocupado;
   assign db_partida      = partida;
   assign db_estado       = r_estado;

endmodule

// File: tb/tb_tx_serial_param.sv
// tb_tx_serial_param: directed bench for tx_serial_param (7O1, 7E1 and 8N2 instances, BAUD_DIV=4).
// Break-path vectors are compiled in with `define TX_BREAK_EN.
module tb_tx_serial_param;

   logic       clock = 1'b0;
   logic       reset;
   logic [2:0] partida;
   logic [6:0] dat0;
   logic [6:0] dat1;
   logic [7:0] dat2;
   logic [2:0] quebra;
   logic [2:0] line, prn, ocp, dbp, dbs;
   logic [3:0] est0, est1, est2;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clock = ~clock;

   tx_serial_param #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .BAUD_DIV(4)) u_7o1 (
      .clock(clock), .reset(reset), .partida(partida[0]), .dados(dat0),
`ifdef TX_BREAK_EN
      .quebra(quebra[0]),
`endif
      .saida_serial(line[0]), .pronto(prn[0]), .ocupado(ocp[0]),
      .db_partida(dbp[0]), .db_saida_serial(dbs[0]), .db_estado(est0));

   tx_serial_param #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(1), .BAUD_DIV(4)) u_7e1 (
      .clock(clock), .reset(reset), .partida(partida[1]), .dados(dat1),
`ifdef TX_BREAK_EN
      .quebra(quebra[1]),
`endif
      .saida_serial(line[1]), .pronto(prn[1]), .ocupado(ocp[1]),
      .db_partida(dbp[1]), .db_saida_serial(dbs[1]), .db_estado(est1));

   tx_serial_param #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .BAUD_DIV(4)) u_8n2 (
      .clock(clock), .reset(reset), .partida(partida[2]), .dados(dat2),
`ifdef TX_BREAK_EN
      .quebra(quebra[2]),
`endif
      .saida_serial(line[2]), .pronto(prn[2]), .ocupado(ocp[2]),
      .db_partida(dbp[2]), .db_saida_serial(dbs[2]), .db_estado(est2));

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic [3:0] get_est(input int s);
      case (s)
         0:       return est0;
         1:       return est1;
         default: return est2;
      endcase
   endfunction

   // Raises partida, then checks every bit cell (4 samples) of the frame, the pronto pulse and the return to idle.
   task automatic run_frame(input int sel, input string tag, input logic [15:0] exp_frame,
                            input int nbits, input int hold, input int chg_at);
      logic [3:0] smp;
      int cyc;
      int npr;
      cyc = 0;
      npr = 0;
      partida[sel] = 1'b1;
      @(negedge clock); cyc++;
      check_eq({tag, "_prep"}, {get_est(sel), ocp[sel], line[sel]}, {4'd1, 1'b1, 1'b1});
      for (int b = 0; b < nbits; b++) begin
         for (int k = 0; k < 4; k++) begin
            @(negedge clock); cyc++;
            if (hold > 0 && cyc == hold) partida[sel] = 1'b0;
            if (cyc == chg_at) dat0 = '0;
            smp[k] = line[sel];
            if (prn[sel]) npr++;
         end
         check_eq($sformatf("%s_bit%0d", tag, b), smp, {4{exp_frame[b]}});
      end
      @(negedge clock);
      check_eq({tag, "_final"}, {get_est(sel), prn[sel], ocp[sel], line[sel]}, {4'd4, 1'b1, 1'b1, 1'b1});
      check_eq({tag, "_early_pronto"}, npr, 0);
      @(negedge clock);
      check_eq({tag, "_idle"}, {get_est(sel), prn[sel], ocp[sel], line[sel]}, {4'd0, 1'b0, 1'b0, 1'b1});
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      reset   = 1'b1;
      partida = '0;
      quebra  = '0;
      dat0    = 7'h35;
      dat1    = 7'h55;
      dat2    = 8'hA5;
      repeat (2) @(negedge clock);
      check_eq("reset_state", {est0, prn[0], ocp[0], line[0]}, {4'd0, 1'b0, 1'b0, 1'b1});
      check_eq("reset_state_8n2", {est2, prn[2], ocp[2], line[2]}, {4'd0, 1'b0, 1'b0, 1'b1});
      reset = 1'b0;
      repeat (2) @(negedge clock);

      // 7O1 0x35: 0,1,0,1,0,1,1,0,par=1,stop=1
      run_frame(0, "t1_7o1_35", 16'h036A, 10, 25, -1);
      repeat (2) @(negedge clock);

      // 7O1 0x7F: 0,1111111,par=0,stop=1; partida left high afterwards
      dat0 = 7'h7F;
      run_frame(0, "t2_7o1_7f", 16'h02FE, 10, 0, -1);
      check_eq("db_partida", {dbp[0], dbs[0]}, {partida[0], line[0]});
      cnt = 0;
      repeat (8) begin
         @(negedge clock);
         if (ocp[0] || prn[0]) cnt++;
      end
      check_eq("t2_no_retrigger", {28'(cnt), est0}, {28'd0, 4'd0});
      partida[0] = 1'b0;
      @(negedge clock);

      // 7E1 0x55: parity 0
      run_frame(1, "t3_7e1_55", 16'h02AA, 10, 0, -1);
      partida[1] = 1'b0;
      // 8N2 0xA5: 0,1,0,1,0,0,1,0,1,1,1
      run_frame(2, "t3_8n2_a5", 16'h074A, 11, 0, -1);
      partida[2] = 1'b0;
      @(negedge clock);

      // dados changed during ESPERA of bit 2; frame still carries 0x35
      dat0 = 7'h35;
      run_frame(0, "t5_latch", 16'h036A, 10, 0, 11);
      partida[0] = 1'b0;
      @(negedge clock);

      // reset 15 cycles into a frame
      dat0       = 7'h35;
      partida[0] = 1'b1;
      repeat (15) @(negedge clock);
      check_eq("t4_midframe", {est0 != 4'd0, ocp[0]}, 2'b11);
      reset = 1'b1;
      #1;
      check_eq("t4_async_reset", {est0, prn[0], ocp[0], line[0]}, {4'd0, 1'b0, 1'b0, 1'b1});
      @(negedge clock);
      reset = 1'b0;
      cnt = 0;
      repeat (6) begin
         @(negedge clock);
         if (prn[0] || ocp[0] || !line[0]) cnt++;
      end
      check_eq("t4_no_restart", cnt, 0);
      partida[0] = 1'b0;
      @(negedge clock);
      run_frame(0, "t4_after_reset", 16'h036A, 10, 0, -1);
      partida[0] = 1'b0;
      @(negedge clock);

`ifdef TX_BREAK_EN
      begin
         int zeros;
         int npr;
         zeros = 0;
         npr   = 0;
         quebra[0] = 1'b1;
         for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (!line[0] && ocp[0] && est0 == 4'd5) zeros++;
            if (prn[0]) npr++;
            if (i == 29) quebra[0] = 1'b0;
         end
         check_eq("t6_break_low", zeros, 30);
         cnt = 0;
         for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (line[0] && ocp[0] && est0 == 4'd5) cnt++;
            if (prn[0]) npr++;
         end
         check_eq("t6_break_stop", cnt, 4);
         @(negedge clock);
         check_eq("t6_break_idle", {est0, prn[0], ocp[0], line[0]}, {4'd0, 1'b0, 1'b0, 1'b1});
         check_eq("t6_break_no_pronto", npr, 0);
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
